// File: rtl/sw_edge_conditioner_if.sv
// Switch conditioner bus: raw switch pins in, clean levels and edge pulses out.
// master = the side that owns the raw pins and consumes the conditioned outputs.
// slave  = the conditioner itself.
interface sw_edge_conditioner_if #(
  parameter int N = 10
);
  logic [N-1:0] sw_raw;
  logic [N-1:0] sw_level;
  logic [N-1:0] sw_rise;
  logic [N-1:0] sw_fall;

  modport master (
    output sw_raw,
    input  sw_level,
    input  sw_rise,
    input  sw_fall
  );

  modport slave (
    input  sw_raw,
    output sw_level,
    output sw_rise,
    output sw_fall
  );
endinterface

// File: rtl/sw_edge_conditioner.sv
// sw_edge_conditioner: per-switch two-flop synchroniser, debouncer and
// registered rise/fall pulse generator for the password lock.
//
// Build option: define SW_DEBOUNCE_EN to build the debounce counters.
// Without it, every synchronised change is accepted on the next cycle
// (behaves as DEBOUNCE_CYCLES = 1), which suits fast simulation and
// sources that are already clean.
module sw_edge_conditioner #(
  parameter int N               = 10,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input logic                   clk,
  input logic                   rst,
  sw_edge_conditioner_if.slave  bus
);

  // Reject configurations where the counter cannot reach its terminal value.
  if (DEBOUNCE_CYCLES < 2 || (2 ** CNT_W) < DEBOUNCE_CYCLES) begin : g_bad_cfg
    $error("sw_edge_conditioner: illegal DEBOUNCE_CYCLES/CNT_W combination");
  end

  logic [N-1:0] s1;
  logic [N-1:0] s2;
  logic [N-1:0] level_q;
  logic [N-1:0] rise_q;
  logic [N-1:0] fall_q;
  logic [N-1:0] commit;   // bit accepts s2 as its new level on this edge

  // Two-flop synchroniser for the asynchronous switch pins.
  // NOTE: every clocked block uses non-blocking assignments so that s2 samples
  // the old s1, not the value written earlier in the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= bus.sw_raw;
      s2 <= s1;
    end
  end

`ifdef SW_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q [N];

  // A bit commits once it has disagreed with its level for the full window.
  // NOTE: the default is assigned before the loop so no path leaves commit
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    commit = '0;
    for (int i = 0; i < N; i++) begin
      commit[i] = (s2[i] != level_q[i]) && (cnt_q[i] == CNT_LAST);
    end
  end

  // Per-bit stability counters: count while s2 differs, clear on agreement or commit.
  // NOTE: this array is a handful of flops, not a RAM, so it is reset like any
  // other register; an in-progress count must be discarded by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (s2[i] == level_q[i] || commit[i]) begin
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end
`else
  // No filtering: any synchronised difference is accepted on the next edge.
  assign commit = s2 ^ level_q;
`endif

  // Clean level plus edge pulses, all updated on the commit edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      // A committing bit always flips, since it differed from s2.
      level_q <= level_q ^ commit;
      rise_q  <= commit & s2;
      fall_q  <= commit & ~s2;
    end
  end

  assign bus.sw_level = level_q;
  assign bus.sw_rise  = rise_q;
  assign bus.sw_fall  = fall_q;

endmodule
